// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, multiply issue-queue entry type and ROB flush test.
package tomasulo_pkg;
  localparam int PHY_ADDR_W   = 6;
  localparam int ROB_TAG_W    = 5;
  localparam int MUL_IQ_DEPTH = 4;
  typedef struct packed {
    logic                  valid;
    logic [PHY_ADDR_W-1:0] rs;
    logic [PHY_ADDR_W-1:0] rt;
    logic [PHY_ADDR_W-1:0] rd;
    logic                  rs_rdy;
    logic                  rt_rdy;
    logic                  reg_write;
    logic [ROB_TAG_W-1:0]  rob_tag;
  } mul_iq_entry_t;
  // Distance from the ROB head wraps naturally in ROB_TAG_W bits.
  function automatic logic rob_is_flushed(input logic [ROB_TAG_W-1:0] tag, input logic [ROB_TAG_W-1:0] top,
                                          input logic [ROB_TAG_W-1:0] depth);
    return ROB_TAG_W'(tag - top) > depth;
  endfunction
endpackage

// File: rtl/mul_iq_entry.sv
// mul_iq_entry: per-slot CDB wakeup, flush match and issue-ready for the multiply issue queue.
module mul_iq_entry import tomasulo_pkg::*; (
  input  mul_iq_entry_t         i_entry,
  input  logic                  i_cdb_hit,
  input  logic [PHY_ADDR_W-1:0] i_cdb_tag,
  input  logic                  i_flush,
  input  logic [ROB_TAG_W-1:0]  i_top,
  input  logic [ROB_TAG_W-1:0]  i_depth,
  output mul_iq_entry_t         o_entry,
  output logic                  o_flushed,
  output logic                  o_ready
);
  always_comb begin
    o_entry        = i_entry;
    o_entry.rs_rdy = i_entry.rs_rdy | (i_entry.valid & i_cdb_hit & (i_cdb_tag == i_entry.rs));
    o_entry.rt_rdy = i_entry.rt_rdy | (i_entry.valid & i_cdb_hit & (i_cdb_tag == i_entry.rt));
  end
  assign o_flushed = i_entry.valid & i_flush & rob_is_flushed(i_entry.rob_tag, i_top, i_depth);
  assign o_ready   = i_entry.valid & i_entry.rs_rdy & i_entry.rt_rdy & ~o_flushed;
endmodule

// File: rtl/issue_queue_mul.sv
// issue_queue_mul: 4-entry collapsing, age-ordered multiply issue queue with CDB wakeup and ROB flush.
// Optional MUL_IQ_PERF_EN adds a saturating stall-cycle counter output Mul_IqStallCnt.
module issue_queue_mul import tomasulo_pkg::*; (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Dis_MulIssquenable,
  input  logic [PHY_ADDR_W-1:0] Dis_RsPhyAddr,
  input  logic [PHY_ADDR_W-1:0] Dis_RtPhyAddr,
  input  logic [PHY_ADDR_W-1:0] Dis_RdPhyAddr,
  input  logic                  Dis_RsDataRdy,
  input  logic                  Dis_RtDataRdy,
  input  logic                  Dis_RegWrite,
  input  logic [ROB_TAG_W-1:0]  Dis_RobTag,
  input  logic                  Cdb_Valid,
  input  logic                  Cdb_RdWrite,
  input  logic [PHY_ADDR_W-1:0] Cdb_RdPhyAddr,
  input  logic                  Cdb_Flush,
  input  logic [ROB_TAG_W-1:0]  Rob_TopPtr,
  input  logic [ROB_TAG_W-1:0]  Cdb_RobDepth,
  input  logic                  Iss_Mult,
  output logic                  Issque_MulReady,
  output logic                  Issque_MulFull,
  output logic [PHY_ADDR_W-1:0] Iss_RsPhyAddrMul,
  output logic [PHY_ADDR_W-1:0] Iss_RtPhyAddrMul,
  output logic [PHY_ADDR_W-1:0] Iss_RdPhyAddr,
  output logic                  Iss_RdWrite,
  output logic [ROB_TAG_W-1:0]  Iss_RobTag
`ifdef MUL_IQ_PERF_EN
  ,output logic [15:0]          Mul_IqStallCnt
`endif
);
  mul_iq_entry_t r_q [MUL_IQ_DEPTH];
  mul_iq_entry_t w_upd [MUL_IQ_DEPTH];
  mul_iq_entry_t w_nxt [MUL_IQ_DEPTH];
  mul_iq_entry_t w_dis;
  mul_iq_entry_t w_sel_e;
  logic [MUL_IQ_DEPTH-1:0] w_valid, w_rdy, w_flushed;
  logic [1:0] w_sel, w_cnt;
  logic w_any, w_issue, w_dis_ok, w_cdb_hit;
  assign w_cdb_hit = Cdb_Valid & Cdb_RdWrite;
  for (genvar g = 0; g < MUL_IQ_DEPTH; g++) begin : g_e
    mul_iq_entry u_e (
      .i_entry  (r_q[g]),
      .i_cdb_hit(w_cdb_hit),
      .i_cdb_tag(Cdb_RdPhyAddr),
      .i_flush  (Cdb_Flush),
      .i_top    (Rob_TopPtr),
      .i_depth  (Cdb_RobDepth),
      .o_entry  (w_upd[g]),
      .o_flushed(w_flushed[g]),
      .o_ready  (w_rdy[g])
    );
    assign w_valid[g] = r_q[g].valid;
  end
  assign Issque_MulFull = &w_valid;
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = MUL_IQ_DEPTH - 1; i >= 0; i--)
      if (w_rdy[i]) begin
        w_sel = 2'(i);
        w_any = 1'b1;
      end
  end
  assign w_issue  = Iss_Mult & w_any;
  assign w_dis_ok = Dis_MulIssquenable & ~Issque_MulFull & ~Cdb_Flush;
  // The entry being dispatched sees the same-cycle CDB broadcast.
  always_comb begin
    w_dis.valid     = 1'b1;
    w_dis.rs        = Dis_RsPhyAddr;
    w_dis.rt        = Dis_RtPhyAddr;
    w_dis.rd        = Dis_RdPhyAddr;
    w_dis.rs_rdy    = Dis_RsDataRdy | (w_cdb_hit & (Cdb_RdPhyAddr == Dis_RsPhyAddr));
    w_dis.rt_rdy    = Dis_RtDataRdy | (w_cdb_hit & (Cdb_RdPhyAddr == Dis_RtPhyAddr));
    w_dis.reg_write = Dis_RegWrite;
    w_dis.rob_tag   = Dis_RobTag;
  end
  // Survivors pack down in age order; dispatch lands just above them.
  always_comb begin
    w_nxt = '{default: '0};
    w_cnt = '0;
    for (int i = 0; i < MUL_IQ_DEPTH; i++)
      if (w_upd[i].valid & ~w_flushed[i] & ~(w_issue & (w_sel == 2'(i)))) begin
        w_nxt[w_cnt] = w_upd[i];
        w_cnt        = w_cnt + 2'd1;
      end
    if (w_dis_ok) w_nxt[w_cnt] = w_dis;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_q <= '{default: '0};
    else       r_q <= w_nxt;
  assign w_sel_e          = r_q[w_sel];
  assign Issque_MulReady  = w_any;
  assign Iss_RsPhyAddrMul = w_any ? w_sel_e.rs : '0;
  assign Iss_RtPhyAddrMul = w_any ? w_sel_e.rt : '0;
  assign Iss_RdPhyAddr    = w_any ? w_sel_e.rd : '0;
  assign Iss_RdWrite      = w_any & w_sel_e.reg_write;
  assign Iss_RobTag       = w_any ? w_sel_e.rob_tag : '0;
`ifdef MUL_IQ_PERF_EN
  logic [15:0] r_stall;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_stall <= '0;
    else if ((|w_valid) & ~w_any & ~(&r_stall)) r_stall <= r_stall + 16'd1;
  assign Mul_IqStallCnt = r_stall;
`endif
endmodule

// File: tb/tb_issue_queue_mul.sv
// tb_issue_queue_mul: directed self-checking bench for issue_queue_mul (define MUL_IQ_PERF_EN to cover the stall counter).
module tb_issue_queue_mul;
  logic Clk = 1'b0, Reset;
  logic Dis_MulIssquenable, Dis_RsDataRdy, Dis_RtDataRdy, Dis_RegWrite;
  logic [5:0] Dis_RsPhyAddr, Dis_RtPhyAddr, Dis_RdPhyAddr, Cdb_RdPhyAddr;
  logic [4:0] Dis_RobTag, Rob_TopPtr, Cdb_RobDepth;
  logic Cdb_Valid, Cdb_RdWrite, Cdb_Flush, Iss_Mult;
  logic Issque_MulReady, Issque_MulFull, Iss_RdWrite;
  logic [5:0] Iss_RsPhyAddrMul, Iss_RtPhyAddrMul, Iss_RdPhyAddr;
  logic [4:0] Iss_RobTag;
`ifdef MUL_IQ_PERF_EN
  logic [15:0] Mul_IqStallCnt;
`endif
  int n_chk = 0, n_err = 0;

  issue_queue_mul dut (
    .Clk(Clk), .Reset(Reset),
    .Dis_MulIssquenable(Dis_MulIssquenable),
    .Dis_RsPhyAddr(Dis_RsPhyAddr), .Dis_RtPhyAddr(Dis_RtPhyAddr), .Dis_RdPhyAddr(Dis_RdPhyAddr),
    .Dis_RsDataRdy(Dis_RsDataRdy), .Dis_RtDataRdy(Dis_RtDataRdy),
    .Dis_RegWrite(Dis_RegWrite), .Dis_RobTag(Dis_RobTag),
    .Cdb_Valid(Cdb_Valid), .Cdb_RdWrite(Cdb_RdWrite), .Cdb_RdPhyAddr(Cdb_RdPhyAddr),
    .Cdb_Flush(Cdb_Flush), .Rob_TopPtr(Rob_TopPtr), .Cdb_RobDepth(Cdb_RobDepth),
    .Iss_Mult(Iss_Mult),
    .Issque_MulReady(Issque_MulReady), .Issque_MulFull(Issque_MulFull),
    .Iss_RsPhyAddrMul(Iss_RsPhyAddrMul), .Iss_RtPhyAddrMul(Iss_RtPhyAddrMul),
    .Iss_RdPhyAddr(Iss_RdPhyAddr), .Iss_RdWrite(Iss_RdWrite), .Iss_RobTag(Iss_RobTag)
`ifdef MUL_IQ_PERF_EN
    ,.Mul_IqStallCnt(Mul_IqStallCnt)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle;
    Dis_MulIssquenable = 1'b0;
    Cdb_Valid = 1'b0; Cdb_RdWrite = 1'b0; Cdb_RdPhyAddr = '0;
    Cdb_Flush = 1'b0; Iss_Mult = 1'b0;
  endtask

  task automatic dis(input logic [4:0] rob, input logic [5:0] rs, input logic rs_rdy, input logic [5:0] rd);
    Dis_MulIssquenable = 1'b1;
    Dis_RobTag = rob; Dis_RsPhyAddr = rs; Dis_RsDataRdy = rs_rdy;
    Dis_RtPhyAddr = 6'd1; Dis_RtDataRdy = 1'b1;
    Dis_RdPhyAddr = rd; Dis_RegWrite = 1'b1;
  endtask

  task automatic wake(input logic [5:0] tag);
    Cdb_Valid = 1'b1; Cdb_RdWrite = 1'b1; Cdb_RdPhyAddr = tag;
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
    idle;
    #1;
  endtask

  initial begin
    idle;
    Reset = 1'b1;
    Dis_RsPhyAddr = '0; Dis_RtPhyAddr = '0; Dis_RdPhyAddr = '0;
    Dis_RsDataRdy = 1'b0; Dis_RtDataRdy = 1'b0; Dis_RegWrite = 1'b0; Dis_RobTag = '0;
    Rob_TopPtr = '0; Cdb_RobDepth = '0;
    #2;
    chk("rst_full", Issque_MulFull, 0);
    chk("rst_ready", Issque_MulReady, 0);
    chk("rst_robtag", Iss_RobTag, 0);
    chk("rst_rd", {Iss_RdWrite, Iss_RdPhyAddr}, 0);
    @(negedge Clk) Reset = 1'b0;
    // fill with four blocked entries
    dis(0, 12, 0, 40); step;
    dis(1, 12, 0, 41); step;
    dis(2, 20, 0, 42); step;
    dis(3, 21, 0, 43); step;
    chk("full4", Issque_MulFull, 1);
    chk("full4_ready", Issque_MulReady, 0);
    Dis_RsDataRdy = 1'b1;
    dis(9, 5, 1, 49); step;
    chk("drop5_full", Issque_MulFull, 1);
    chk("drop5_ready", Issque_MulReady, 0);
    Cdb_Valid = 1'b1; Cdb_RdWrite = 1'b0; Cdb_RdPhyAddr = 6'd20; step;
    chk("cdb_nowrite", Issque_MulReady, 0);
    wake(12); #1;
    chk("wake_delay", Issque_MulReady, 0);
    step;
    chk("wake_ready", Issque_MulReady, 1);
    chk("wake_robtag", Iss_RobTag, 0);
    chk("wake_rd", Iss_RdPhyAddr, 40);
    chk("wake_rs_rt", {Iss_RsPhyAddrMul, Iss_RtPhyAddrMul}, {6'd12, 6'd1});
    chk("wake_rdwrite", Iss_RdWrite, 1);
    Iss_Mult = 1'b1; step;
    chk("grant_full", Issque_MulFull, 0);
    chk("grant_shift_tag", Iss_RobTag, 1);
    chk("grant_shift_rd", Iss_RdPhyAddr, 41);
    Iss_Mult = 1'b1; step;
    chk("grant2_ready", Issque_MulReady, 0);
    // index-1 issue with simultaneous dispatch
    dis(4, 22, 0, 44); wake(21); step;
    chk("sel_idx1", Iss_RobTag, 3);
    Iss_Mult = 1'b1; dis(5, 23, 0, 45); step;
    chk("iss_dis_ready", Issque_MulReady, 0);
    chk("iss_dis_full", Issque_MulFull, 0);
    wake(23); step;
    chk("order_idx2", Iss_RobTag, 5);
    wake(22); step;
    chk("order_idx1", Iss_RobTag, 4);
    // asynchronous reset mid-operation
    #2 Reset = 1'b1; #1;
    chk("async_rst_ready", Issque_MulReady, 0);
    chk("async_rst_tag", Iss_RobTag, 0);
    @(negedge Clk) Reset = 1'b0;
    chk("post_rst_ready", Issque_MulReady, 0);
    // dispatch racing its own wakeup
    dis(6, 7, 0, 46); wake(7); step;
    chk("dis_wake_ready", Issque_MulReady, 1);
    chk("dis_wake_tag", Iss_RobTag, 6);
    Iss_Mult = 1'b1; step;
    chk("empty_ready", Issque_MulReady, 0);
    chk("empty_tag", Iss_RobTag, 0);
    // flush boundary around the ROB wrap
    Rob_TopPtr = 5'd30; Cdb_RobDepth = 5'd2;
    dis(31, 30, 0, 50); step;
    dis(1, 30, 1, 51); step;
    dis(3, 30, 0, 52); step;
    chk("pre_flush_tag", Iss_RobTag, 1);
    Cdb_Flush = 1'b1; Iss_Mult = 1'b1; dis(9, 5, 1, 53); #1;
    chk("flush_mask", Issque_MulReady, 0);
    step;
    chk("post_flush_ready", Issque_MulReady, 0);
    wake(30); step;
    chk("survivor_tag", Iss_RobTag, 31);
    dis(10, 50, 0, 54); step;
    dis(11, 50, 0, 55); step;
    chk("flush_count3", Issque_MulFull, 0);
    dis(12, 50, 0, 56); step;
    chk("flush_count4", Issque_MulFull, 1);
    Iss_Mult = 1'b1; dis(13, 5, 1, 57); step;
    chk("full_iss_dis_full", Issque_MulFull, 0);
    chk("full_iss_dis_ready", Issque_MulReady, 0);
`ifdef MUL_IQ_PERF_EN
    Reset = 1'b1; #1 Reset = 1'b0;
    dis(20, 60, 0, 58); step;
    dis(21, 61, 0, 59); step;
    chk("stall_1", Mul_IqStallCnt, 1);
    repeat (9) step;
    chk("stall_10", Mul_IqStallCnt, 10);
    Reset = 1'b1; #1;
    chk("stall_rst", Mul_IqStallCnt, 0);
    Reset = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/issue_queue_mul.md
ISSUE_QUEUE_MUL -- requirements
Module: issue_queue_mul

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports listed below, clock and reset first.
REQ-002 Clk  in  1  sole clock, all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high.
REQ-004 Dis_MulIssquenable  in  1  dispatch writes one mult instruction this cycle.
REQ-005 Dis_RsPhyAddr, Dis_RtPhyAddr, Dis_RdPhyAddr  in  6 each  source and destination physical tags.
REQ-006 Dis_RsDataRdy, Dis_RtDataRdy  in  1 each  source operand already available.
REQ-007 Dis_RegWrite  in  1; Dis_RobTag  in  5  carried unchanged to issue.
REQ-008 Cdb_Valid  in  1; Cdb_RdWrite  in  1; Cdb_RdPhyAddr  in  6  result broadcast for wakeup.
REQ-009 Cdb_Flush  in  1; Rob_TopPtr  in  5; Cdb_RobDepth  in  5  mispredict flush boundary.
REQ-010 Iss_Mult  in  1  grant from issue unit.
REQ-011 Issque_MulReady  out  1; Issque_MulFull  out  1.
REQ-012 Iss_RsPhyAddrMul, Iss_RtPhyAddrMul, Iss_RdPhyAddr  out  6 each; Iss_RdWrite  out  1; Iss_RobTag  out  5  fields of selected entry, feed the multiplier and register file.

Function
REQ-013 SHALL hold 4 entries in collapsing, age-ordered form: index 0 oldest, valid entries contiguous from 0.
REQ-014 Entry fields: valid, Rs/Rt/Rd tags, Rs/Rt ready, RegWrite, RobTag.
REQ-015 Issque_MulFull SHALL be 1 exactly when all 4 valid (combinational, no credit for same-cycle issue); dispatch while full SHALL be ignored.
REQ-016 Wakeup: Cdb_Valid && Cdb_RdWrite && tag match SHALL set that source ready at next edge, for resident entries and for the entry being dispatched in the same cycle.
REQ-017 Selection: lowest-index valid entry with both sources ready and not flushed this cycle; Issque_MulReady SHALL be 1 when such an entry exists; Iss_* outputs SHALL show it combinationally (all-zero when none).
REQ-018 Iss_Mult with Issque_MulReady SHALL remove the selected entry at the edge; younger entries shift down one index; Iss_Mult without Ready SHALL be ignored.
REQ-019 New dispatch SHALL land at the first free index after removal/shift in the same edge; issue plus dispatch when full SHALL still ignore dispatch (REQ-015).
REQ-020 Flush: entry with ((RobTag - Rob_TopPtr) mod 32) > Cdb_RobDepth SHALL be invalidated at the edge; dispatch during Cdb_Flush SHALL be ignored.
REQ-021 Issue-to-multiplier latency: zero cycles (grant edge is the multiplier capture edge); one issue per cycle maximum.
REQ-022 A source already ready SHALL stay ready; wakeup on an invalid entry SHALL have no effect.

Reset
REQ-023 Reset SHALL clear all valid bits and zero all entry fields immediately, independent of Clk; Issque_MulFull=0, Issque_MulReady=0, all Iss_* outputs=0.
REQ-024 Reset asserted mid-operation SHALL discard all entries; no issue in the cycle Reset deasserts unless dispatched and ready.

Configuration
REQ-025 Macro MUL_IQ_PERF_EN defined: extra output Mul_IqStallCnt (out 16) counts cycles with ≥1 valid entry and Issque_MulReady=0, saturating at 16'hFFFF, reset to 0.
REQ-026 MUL_IQ_PERF_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-027 Shared package tomasulo_pkg SHALL hold PHY_ADDR_W=6, ROB_TAG_W=5, MUL_IQ_DEPTH=4, entry struct typedef and rob_is_flushed(tag, top, depth) function.
REQ-028 One sub-module mul_iq_entry (per-entry wakeup/ready/flush-match logic) SHALL be instantiated 4 times; selection and compaction live in issue_queue_mul.

Verification
REQ-029 Dispatch 4 entries with sources not ready -> Issque_MulFull=1, Issque_MulReady=0; 5th dispatch dropped.
REQ-030 Entries 0,1 waiting on tag 6'd12; Cdb_Valid=1, Cdb_RdWrite=1, Cdb_RdPhyAddr=12 -> next cycle Ready=1, Iss_RobTag = entry 0 tag; grant -> entry 1 at index 0.
REQ-031 Dispatch Rs tag 6'd7 not ready while CDB broadcasts 7, Rt ready -> entry ready next cycle.
REQ-032 Rob_TopPtr=30, tags 31,1,3 resident, Cdb_Flush=1, Cdb_RobDepth=2 -> only tag 31 survives (depth 1), tags 1 (3) and 3 (5) removed.
REQ-033 Issue of index 1 plus dispatch in same cycle with 3 valid -> 3 valid, new entry at index 2, order preserved.
REQ-034 MUL_IQ_PERF_EN defined: 10 cycles with 2 blocked entries -> Mul_IqStallCnt=10; Reset pulse -> 0.
